// File: rtl/cdma_lite_copy_if.sv
// AXI4-Lite write-only channel bundle (AW/W/B) between the CDMA
// programming master and the cdma_lite_copy register slave.
//   awaddr/awvalid/awready : write address (10-bit byte offset)
//   wdata/wvalid/wready    : write data (32-bit)
//   bresp/bvalid/bready    : write response (OKAY 2'b00 / SLVERR 2'b10)
interface cdma_lite_copy_if;
  logic [9:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output awaddr, awvalid, wdata, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/cdma_lite_copy.sv
// AXI4-Lite write-slave register file (SA/DA/BTT) plus word-copy engine.
// A write to BTT launches a memory-to-memory copy of BTT[BTT_W-1:2] words
// through a single-port memory with 1-cycle read latency.
//   clk, rst_n          : clock, synchronous active-low reset
//   bus (slave)         : AW/W/B write channels
//   mem_en/mem_we       : memory strobe / write select
//   mem_addr/mem_wdata  : word-aligned byte address / write data
//   mem_rdata           : read data, valid the cycle after a read strobe
//   busy                : copy in progress (stalls register writes)
//   copy_done           : one-cycle completion pulse
module cdma_lite_copy #(
  parameter int unsigned BTT_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  cdma_lite_copy_if.slave   bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              copy_done
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [BTT_W-3:0] CNT_ONE = 1;

  state_t            state, state_nx;
  logic [31:2]       sa, da;
  logic [31:0]       src, dst;
  logic [BTT_W-3:0]  cnt;
  logic [BTT_W-3:0]  n_words;
  logic              accept, sel_sa, sel_da, sel_btt, start;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  assign accept  = bus.awvalid & bus.wvalid & ~busy & (~bus.bvalid | bus.bready);
  assign sel_sa  = (bus.awaddr == 10'h018);
  assign sel_da  = (bus.awaddr == 10'h020);
  assign sel_btt = (bus.awaddr == 10'h028);
  assign n_words = bus.wdata[BTT_W-1:2];
  assign start   = accept & sel_btt;

  assign bus.awready = accept;
  assign bus.wready  = accept;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;

  // SA/DA keep only the word-address bits. The BTT value itself is never
  // needed after launch: its word count is loaded straight into cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa       <= '0;
      da       <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
    end else begin
      if (accept) begin
        if (sel_sa) sa <= bus.wdata[31:2];
        if (sel_da) da <= bus.wdata[31:2];
        bvalid_q <= 1'b1;
        bresp_q  <= (sel_sa | sel_da | sel_btt) ? 2'b00 : 2'b10;
      end else if (bus.bready) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = (n_words != '0) ? READ : DONE;
      READ:  state_nx = WRITE;
      WRITE: state_nx = (cnt == CNT_ONE) ? DONE : READ;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src <= '0;
      dst <= '0;
      cnt <= '0;
    end else if (start) begin
      src <= {sa, 2'b00};
      dst <= {da, 2'b00};
      cnt <= n_words;
    end else if (state == WRITE) begin
      src <= src + 32'd4;
      dst <= dst + 32'd4;
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    copy_done = 1'b0;
    unique case (state)
      READ: begin
        mem_en   = 1'b1;
        mem_addr = src;
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst;
        mem_wdata = mem_rdata;
      end
      DONE:    copy_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/cdma_lite_copy.md
# cdma_lite_copy

AXI4-Lite write-slave register file plus word-copy engine that receives the SA/DA/BTT programming sequence issued by the CDMA control stage and performs the memory-to-memory transfer. The block sits directly downstream of the CDMA programming master on the AW/W/B channels. It moves data between the boot/program source regions and the instruction/data RAM through a single-port memory interface. A write to BTT launches the copy. `copy_done` signals completion to the SoC.

## Interface
Parameters:
- `BTT_W`, 23: significant bits of the BTT register; higher `wdata` bits are discarded.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `awaddr`  in  10  write address (byte offset).
- `awvalid`  in  1  write address valid.
- `awready`  out  1  write address ready.
- `wdata`  in  32  write data.
- `wvalid`  in  1  write data valid.
- `wready`  out  1  write data ready.
- `bresp`  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- `bvalid`  out  1  write response valid.
- `bready`  in  1  write response ready.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  32  byte address, always word aligned.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  read data, valid exactly 1 cycle after a read strobe.
- `busy`  out  1  copy in progress.
- `copy_done`  out  1  one-cycle pulse at copy completion.

## Operation
- **Register map (write-only):**
  - 0x18 SA (source address).
  - 0x20 DA (destination address).
  - 0x28 BTT (bytes to transfer). A BTT write starts the copy.
  - Any other `awaddr`: no register change; response SLVERR.
  - All mapped offsets: response OKAY.
- **Write acceptance:** `awready = wready = awvalid & wvalid & ~busy & (~bvalid | bready)`. AW and W are always accepted together in one cycle; one channel valid alone is never accepted.
- **Address alignment:** SA[1:0] and DA[1:0] are forced to 0 when used.
- **Word count:** N = BTT[BTT_W-1:2]. BTT[1:0] is ignored, so partial trailing bytes are not copied.
- **Copy FSM states:** IDLE, READ, WRITE, DONE.
  - IDLE -> READ: on an accepted BTT write with N > 0. Load `src = SA`, `dst = DA`, `cnt = N`.
  - IDLE -> DONE: on an accepted BTT write with N = 0. No memory access occurs.
  - READ: `mem_en = 1`, `mem_we = 0`, `mem_addr = src`. Next state WRITE.
  - WRITE: `mem_en = 1`, `mem_we = 1`, `mem_addr = dst`, `mem_wdata = mem_rdata`. Then `src += 4`, `dst += 4`, `cnt -= 1`. Next state DONE if `cnt == 1`, else READ.
  - DONE: `copy_done = 1`. Next state IDLE.
- **Outputs:** `busy = (state != IDLE)`. `mem_en`, `mem_we`, `mem_addr`, `mem_wdata` are 0 in IDLE and DONE.
- **Address arithmetic:** `src`/`dst` wrap modulo 2^32; no range checking.
- **Register persistence:** SA/DA/BTT keep their values after a copy. Rewriting only BTT repeats a copy with the previous SA/DA.

## Timing
- **Reset values:** all outputs 0, state IDLE, SA/DA/BTT = 0.
  - Reset asserted mid-copy aborts immediately: no further memory strobe, no `copy_done`, `bvalid` cleared.
- **B channel:**
  - `bvalid` rises the cycle after acceptance and holds with stable `bresp` until `bvalid & bready`.
  - With `bready` tied high, back-to-back writes are accepted every cycle (SA, DA, BTT in 3 consecutive cycles).
- **Copy timing:**
  - Cycle after BTT acceptance: first READ.
  - N words take 2N cycles; DONE follows in cycle 2N+1 after acceptance.
  - N = 0: DONE is the cycle after acceptance.
- **Busy back-pressure:** while `busy`, `awready`/`wready` stay low, so any SA/DA/BTT write is stalled until the cycle after DONE. A pending B response still completes normally.
- **Throughput:** `mem_en` is a one-cycle strobe per access; the memory never stalls.

## Test plan
- **Basic copy:** SA=0x00020000, DA=0x00000000, BTT=20 in 3 consecutive cycles, `bready=1`, memory preloaded with 0xA0..0xA4 -> 5 READ/WRITE pairs at 0x20000+4i / 0x0+4i, destination holds the same words, `copy_done` pulses exactly 11 cycles after BTT acceptance, 3 OKAY responses.
- **Zero/partial length:** BTT=3 -> no `mem_en`, `busy` high 1 cycle, `copy_done` the cycle after acceptance. BTT=7 -> exactly 1 word copied.
- **Unmapped address:** write `awaddr`=0x1C, `wdata`=0xDEADBEEF -> `bresp`=2'b10, SA/DA/BTT unchanged, no copy.
- **B back-pressure:** `bready=0` after the SA write -> `bvalid` held with `bresp` stable, `awready`/`wready` low on the next offered write until `bready` rises.
- **Program during busy:** issue a new SA write during a 4-word copy -> stalled with ready low until the cycle after DONE, then accepted; the running copy uses the old SA throughout.
- **Reset mid-copy:** assert `rst_n=0` in the second READ of an 8-word copy -> next cycle all outputs 0, no `copy_done`. After release, SA/DA/BTT = 0 and a fresh BTT=8 copies from address 0.
